dmem_ctrl: RTL and testbench

Data-memory access controller sitting directly downstream of the load/store unit in the MEM stage. It takes the LSU's word-level request (address, write enable, bit write mask, write data) and aligns data and mask to the byte lane given by addr[1:0]. It runs a grant/response handshake with a variable-latency data memory and stalls the pipeline until the access completes. Load data is shifted back to bit 0 before it returns to the LSU for sign/zero extension, and misaligned or timed-out accesses are flagged.

---
 rtl/dmem_ctrl.sv | 150 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: lane-aligns LSU requests, runs a gnt/rvalid
// handshake with a variable-latency memory, and stalls the core until completion.
module dmem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_bit_wr_en,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_bit_wr_en,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       off_reg;
  logic [31:0]      addr_reg, mask_reg, wdata_reg, rd_hold_reg;
  logic             we_reg;

  logic [1:0]  off;
  logic [4:0]  req_shamt, rsp_shamt;
  logic [31:0] aligned_rdata;
  logic        misaligned, timeout_hit;
  logic        accept, complete, load_done, misalign_c, bus_err_c;

  assign off           = req_addr[1:0];
  assign req_shamt     = {off, 3'b000};
  assign rsp_shamt     = {off_reg, 3'b000};
  assign aligned_rdata = mem_rdata >> rsp_shamt;
  assign timeout_hit   = (cnt_reg == CNT_LAST);

  // Byte accesses can never straddle a word; size 3 behaves as a word.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = (off == 2'd3);
      default: misaligned = (off != 2'd0);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    load_done  = 1'b0;
    misalign_c = 1'b0;
    bus_err_c  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid && rst_n) begin
          if (misaligned) begin
            misalign_c = 1'b1;
          end else begin
            accept     = 1'b1;
            cnt_next   = '0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // A grant in the timeout cycle still wins over the bus error.
        if (mem_gnt) begin
          cnt_next = '0;
          if (we_reg) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RESP;
          end
        end else if (timeout_hit) begin
          bus_err_c  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          complete   = 1'b1;
          load_done  = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          bus_err_c  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      off_reg     <= '0;
      addr_reg    <= '0;
      mask_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      rd_hold_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= {req_addr[31:2], 2'b00};
        we_reg    <= req_we;
        off_reg   <= off;
        mask_reg  <= req_we ? (req_bit_wr_en << req_shamt) : 32'd0;
        wdata_reg <= req_wdata << req_shamt;
      end
      if (load_done) begin
        rd_hold_reg <= aligned_rdata;
      end
    end
  end

  assign mem_req       = (state_reg == REQ);
  assign mem_we        = we_reg;
  assign mem_addr      = addr_reg;
  assign mem_bit_wr_en = mask_reg;
  assign mem_wdata     = wdata_reg;
  assign misalign      = misalign_c;
  assign bus_err       = bus_err_c;
  assign stall         = req_valid & ~(complete | misalign_c | bus_err_c);
  assign rd_data       = load_done ? aligned_rdata : rd_hold_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected memory/response
// events, a negedge monitor pops and compares whenever the DUT presents one.
module tb_dmem_ctrl;

  localparam int K_BUS = 0, K_RD = 1, K_MIS = 2, K_BERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_bit_wr_en = '0, req_wdata = '0;
  logic        stall, misalign, bus_err, mem_req, mem_we;
  logic [31:0] rd_data, mem_addr, mem_bit_wr_en, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_bit_wr_en(req_bit_wr_en), .req_wdata(req_wdata),
    .stall(stall), .rd_data(rd_data), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_bit_wr_en(mem_bit_wr_en), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic we,
                      input logic [31:0] mask, input logic [31:0] wdata,
                      input logic [31:0] rdata);
    exp_t e;
    e.kind = kind; e.addr = addr; e.we = we;
    e.mask = mask; e.wdata = wdata; e.rdata = rdata;
    q.push_back(e);
  endtask

  task automatic pop_expect(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: '0};
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n) begin
      if (mem_req && mem_gnt) begin
        pop_expect(K_BUS, e, ok);
        if (ok) begin
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_bit_wr_en", mem_bit_wr_en, e.mask);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (req_valid && !req_we && !stall && !misalign && !bus_err) begin
        pop_expect(K_RD, e, ok);
        if (ok) chk("rd_data", rd_data, e.rdata);
      end
      if (misalign) pop_expect(K_MIS, e, ok);
      if (bus_err)  pop_expect(K_BERR, e, ok);
    end
  end

  // Drive one request; g/r are the cycle indices (0 = accept cycle) of gnt/rvalid.
  task automatic do_access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] mask, input logic [31:0] wdata,
                           input int g, input int r, input logic [31:0] rdata,
                           output int n);
    int  k;
    bit  done;
    n = 0; k = 0; done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr;
    req_bit_wr_en = mask; req_wdata = wdata; mem_rdata = rdata;
    mem_gnt = (k == g); mem_rvalid = (k == r);
    while (!done) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 40) begin
          checks++; errors++;
          $display("FAIL access_bound: got stall after %0d cycles expected release", n);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
          k++;
          mem_gnt = (k == g); mem_rvalid = (k == r);
        end
      end
    end
    $display("txn we=%0d size=%0d addr=%h wdata=%h stall_cycles=%0d rd_data=%h",
             we, sz, addr, wdata, n, rd_data);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
    end
  endtask

  task automatic misal(input logic [1:0] sz, input logic [31:0] addr, input logic we);
    push(K_MIS, '0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr;
    req_bit_wr_en = '1; req_wdata = 32'h1234_5678;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("misal_pulse", 32'(misalign), 32'd1);
    chk("misal_stall", 32'(stall), 32'd0);
    chk("misal_mem_req", 32'(mem_req), 32'd0);
    $display("txn misaligned size=%0d addr=%h misalign=%0d", sz, addr, misalign);
    idle(1);
  endtask

  initial begin
    int n;
    // Reset state with a request already presented.
    req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h100;
    #12;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    req_valid = 1'b0;
    #1 rst_n = 1'b1;
    idle(1);

    // SW 0x100
    push(K_BUS, 32'h100, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, '0);
    do_access(1'b1, 2'd2, 32'h100, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1, -1, '0, n);
    chk("sw_stall_cycles", 32'(n), 32'd1);
    idle(1);

    // SB 0x203
    push(K_BUS, 32'h200, 1'b1, 32'hFF00_0000, 32'hA500_0000, '0);
    do_access(1'b1, 2'd0, 32'h203, 32'h0000_00FF, 32'h0000_00A5, 1, -1, '0, n);
    chk("sb_stall_cycles", 32'(n), 32'd1);
    idle(1);

    // SH 0x702
    push(K_BUS, 32'h700, 1'b1, 32'hFFFF_0000, 32'hBEEF_0000, '0);
    do_access(1'b1, 2'd1, 32'h702, 32'h0000_FFFF, 32'h0000_BEEF, 1, -1, '0, n);
    chk("sh_stall_cycles", 32'(n), 32'd1);
    idle(1);

    // LH 0x302, gnt delayed 3 cycles, rvalid 2 cycles later
    push(K_BUS, 32'h300, 1'b0, 32'h0, 32'h0, '0);
    push(K_RD, '0, 1'b0, '0, '0, 32'h0000_8001);
    do_access(1'b0, 2'd1, 32'h302, 32'hFFFF_FFFF, 32'h0, 4, 6, 32'h8001_1234, n);
    chk("lh_stall_cycles", 32'(n), 32'd6);
    idle(2);
    chk("rd_data_held", rd_data, 32'h0000_8001);

    // Misalignment cases
    misal(2'd2, 32'h101, 1'b0);
    misal(2'd1, 32'h103, 1'b0);
    misal(2'd2, 32'h102, 1'b1);
    push(K_BUS, 32'h100, 1'b0, 32'h0, 32'h0, '0);
    push(K_RD, '0, 1'b0, '0, '0, 32'h0000_ABCD);
    do_access(1'b0, 2'd1, 32'h101, 32'h0, 32'h0, 1, 2, 32'h00AB_CD00, n);
    chk("lh101_stall_cycles", 32'(n), 32'd2);
    idle(1);

    // Timeout: no grant at all
    push(K_BERR, '0, 1'b0, '0, '0, '0);
    do_access(1'b0, 2'd2, 32'h400, 32'h0, 32'h0, -1, -1, 32'h1234_5678, n);
    chk("timeout_stall_cycles", 32'(n), 32'd16);
    idle(1);

    // Grant in the timeout cycle wins
    push(K_BUS, 32'h400, 1'b0, 32'h0, 32'h0, '0);
    push(K_RD, '0, 1'b0, '0, '0, 32'h1234_5678);
    do_access(1'b0, 2'd2, 32'h400, 32'h0, 32'h0, 16, 17, 32'h1234_5678, n);
    chk("late_gnt_stall_cycles", 32'(n), 32'd17);
    idle(1);

    // Reset during RESP, then a late rvalid
    push(K_BUS, 32'h500, 1'b0, 32'h0, 32'h0, '0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h500;
    req_bit_wr_en = '0; req_wdata = '0; mem_gnt = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    chk("midrst_stall", 32'(stall), 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_rvalid_rd_data", rd_data, 32'd0);
    chk("late_rvalid_stall", 32'(stall), 32'd0);
    $display("txn reset_in_resp rd_data=%h mem_req=%0d", rd_data, mem_req);
    idle(1);

    // Back-to-back SW then LW
    push(K_BUS, 32'h600, 1'b1, 32'hFFFF_FFFF, 32'h1122_3344, '0);
    push(K_BUS, 32'h604, 1'b0, 32'h0, 32'h0, '0);
    push(K_RD, '0, 1'b0, '0, '0, 32'hCAFE_F00D);
    do_access(1'b1, 2'd2, 32'h600, 32'hFFFF_FFFF, 32'h1122_3344, 1, -1, '0, n);
    chk("b2b_sw_stall_cycles", 32'(n), 32'd1);
    do_access(1'b0, 2'd2, 32'h604, 32'h0, 32'h0, 1, 2, 32'hCAFE_F00D, n);
    chk("b2b_lw_stall_cycles", 32'(n), 32'd2);
    idle(2);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
